// File: rtl/pdm_pkg.sv
// Shared types and constants for the PDM transmitter.
package pdm_pkg;

  localparam int PCM_WIDTH_DEF = 16;
  localparam int OSR_DEF       = 50;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pdm_tx_state_t;

  // Two guard bits keep the first-order accumulator inside [-4*FS, 4*FS).
  function automatic int acc_width(input int pcm_width);
    return pcm_width + 2;
  endfunction

  function automatic int fs_of(input int pcm_width);
    return 1 << (pcm_width - 1);
  endfunction

  function automatic int osr_cnt_width(input int osr);
    return (osr > 1) ? $clog2(osr) : 1;
  endfunction

endpackage

// File: rtl/pdm_sd_mod.sv
// First-order sigma-delta modulator core: one registered PDM bit per step strobe.
module pdm_sd_mod
  import pdm_pkg::*;
#(
  parameter int PCM_WIDTH = PCM_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        step,
  input  logic signed [PCM_WIDTH-1:0] sample,
  output logic                        bit_out
);

  localparam int ACC_W = acc_width(PCM_WIDTH);
  localparam logic signed [ACC_W-1:0] FS = ACC_W'(fs_of(PCM_WIDTH));

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] fb;
  logic                    bit_q, bit_d;
  logic                    bit_now;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    acc_d      = acc_q;
    bit_d      = bit_q;
    bit_now    = !acc_q[ACC_W-1];
    sample_ext = {{(ACC_W-PCM_WIDTH){sample[PCM_WIDTH-1]}}, sample};
    fb         = bit_now ? FS : -FS;
    if (clr) begin
      acc_d = '0;
      bit_d = 1'b0;
    end else if (step) begin
      acc_d = acc_q + sample_ext - fb;
      bit_d = bit_now;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      bit_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      bit_q <= bit_d;
    end
  end

  assign bit_out = bit_q;

endmodule

// File: rtl/pdm_tx.sv
// PDM transmitter: one-entry PCM holding buffer, OSR sequencing and sigma-delta output.
// Optional underrun counter port is built when PDM_TX_UNDERRUN_CNT_EN is defined.
module pdm_tx
  import pdm_pkg::*;
#(
  parameter int PCM_WIDTH = PCM_WIDTH_DEF,
  parameter int OSR       = OSR_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        m_clk_rising,
  input  logic signed [PCM_WIDTH-1:0] pcm_data,
  input  logic                        pcm_valid,
  output logic                        pcm_ready,
  output logic                        M_DATA,
  output logic                        underrun
`ifdef PDM_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                 underrun_cnt
`endif
);

  localparam int CNT_W = osr_cnt_width(OSR);
  localparam logic [CNT_W-1:0] OSR_LAST = CNT_W'(OSR - 1);

  pdm_tx_state_t state_q, state_d;

  logic signed [PCM_WIDTH-1:0] buf_q, buf_d;
  logic                        buf_full_q, buf_full_d;
  logic signed [PCM_WIDTH-1:0] cur_q, cur_d;
  logic [CNT_W-1:0]            osr_cnt_q, osr_cnt_d;
  logic                        underrun_q, underrun_d;

  logic                        run;
  logic                        step;
  logic                        boundary;
  logic                        consume;
  logic                        starve;
  logic                        accept;
  logic signed [PCM_WIDTH-1:0] mod_sample;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = RUN;
      RUN:     if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run      = (state_q == RUN);
    step     = run && m_clk_rising;
    boundary = step && (osr_cnt_q == '0);
    consume  = boundary && buf_full_q;
    starve   = boundary && !buf_full_q;
    // Ready is registered, so an accept can only land in an empty buffer and never collides with consume.
    accept   = pcm_valid && !buf_full_q;

    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (accept) begin
      buf_d      = pcm_data;
      buf_full_d = 1'b1;
    end else if (consume) begin
      buf_full_d = 1'b0;
    end

    cur_d = cur_q;
    if (consume)     cur_d = buf_q;
    else if (starve) cur_d = '0;

    // The modulator sees the freshly selected sample on the boundary strobe itself.
    if (consume)     mod_sample = buf_q;
    else if (starve) mod_sample = '0;
    else             mod_sample = cur_q;

    osr_cnt_d = osr_cnt_q;
    if (!run)
      osr_cnt_d = '0;
    else if (step)
      osr_cnt_d = (osr_cnt_q == OSR_LAST) ? '0 : osr_cnt_q + CNT_W'(1);

    underrun_d = starve;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      cur_q      <= '0;
      osr_cnt_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      cur_q      <= cur_d;
      osr_cnt_q  <= osr_cnt_d;
      underrun_q <= underrun_d;
    end
  end

  pdm_sd_mod #(
    .PCM_WIDTH (PCM_WIDTH)
  ) u_mod (
    .clk     (clk),
    .rst     (rst),
    .clr     (!run),
    .step    (step),
    .sample  (mod_sample),
    .bit_out (M_DATA)
  );

  assign pcm_ready = !buf_full_q;
  assign underrun  = underrun_q;

`ifdef PDM_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (starve && (ucnt_q != 16'hFFFF))
      ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ucnt_q <= '0;
    else     ucnt_q <= ucnt_d;
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_pdm_tx.sv
// Self-checking bench for pdm_tx: density vector table plus handshake, underrun and reset sequences.
module tb_pdm_tx;

  localparam int PCM_WIDTH = 16;
  localparam int OSR       = 50;
  localparam int FS        = 32768;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        en;
  logic                        m_clk_rising;
  logic signed [PCM_WIDTH-1:0] pcm_data;
  logic                        pcm_valid;
  logic                        pcm_ready;
  logic                        M_DATA;
  logic                        underrun;
`ifdef PDM_TX_UNDERRUN_CNT_EN
  logic [15:0]                 underrun_cnt;
`endif

  pdm_tx #(
    .PCM_WIDTH (PCM_WIDTH),
    .OSR       (OSR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .m_clk_rising (m_clk_rising),
    .pcm_data     (pcm_data),
    .pcm_valid    (pcm_valid),
    .pcm_ready    (pcm_ready),
    .M_DATA       (M_DATA),
    .underrun     (underrun)
`ifdef PDM_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #4 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state (behavioural, integer arithmetic)
  bit   m_run, m_full;
  int   m_buf, m_cur, m_acc, m_cnt, m_ucnt;
  logic e_mdata, e_under;

  int   src_q[$];
  int   ones;
  int   under_seen;
  logic last_bit;

  typedef struct {
    int x;
    int lo;
    int hi;
  } dens_vec_t;

  dens_vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_full = 0; m_buf = 0; m_cur = 0; m_acc = 0; m_cnt = 0; m_ucnt = 0;
    e_mdata = 1'b0; e_under = 1'b0;
  endtask

  // One clock: drive at negedge, let the posedge happen, update model, compare at next negedge.
  task automatic cycle(input logic strb);
    logic acc_ok, pre_full, b;
    int   d;
    pcm_valid    = (src_q.size() > 0);
    d            = pcm_valid ? src_q[0] : 0;
    pcm_data     = 16'(d);
    m_clk_rising = strb;
    acc_ok       = pcm_valid && pcm_ready;
    @(negedge clk);
    if (acc_ok) void'(src_q.pop_front());

    pre_full = m_full;
    e_under  = 1'b0;
    if (!m_run) begin
      m_acc = 0; m_cnt = 0; e_mdata = 1'b0;
    end else if (strb) begin
      if (m_cnt == 0) begin
        if (pre_full) begin
          m_cur = m_buf; m_full = 0;
        end else begin
          m_cur = 0; e_under = 1'b1;
          if (m_ucnt < 65535) m_ucnt++;
        end
      end
      b       = (m_acc >= 0);
      m_acc   = m_acc + m_cur - (b ? FS : -FS);
      e_mdata = b;
      m_cnt   = (m_cnt + 1) % OSR;
    end
    if (pcm_valid && !pre_full) begin
      m_buf = d; m_full = 1;
    end
    m_run = en;

    if (underrun === 1'b1) under_seen++;
    check("m_data", M_DATA, e_mdata);
    check("pcm_ready", pcm_ready, !m_full);
    check("underrun", underrun, e_under);
`ifdef PDM_TX_UNDERRUN_CNT_EN
    check("underrun_cnt", underrun_cnt, m_ucnt);
`endif
    m_clk_rising = 1'b0;
  endtask

  task automatic run_strobes(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1);
      last_bit = M_DATA;
      if (M_DATA === 1'b1) ones++;
      repeat (3) cycle(1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_q.delete();
    pcm_valid    = 1'b0;
    m_clk_rising = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_run();
    en = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
  endtask

  initial begin
    vecs[0] = '{x: 0,      lo: 25, hi: 25};
    vecs[1] = '{x: 16384,  lo: 37, hi: 38};
    vecs[2] = '{x: -32768, lo: 0,  hi: 0};
    vecs[3] = '{x: 32767,  lo: 49, hi: 50};

    rst = 1'b1; en = 1'b0; m_clk_rising = 1'b0; pcm_valid = 1'b0; pcm_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_m_data", M_DATA, 1'b0);
    check("reset_pcm_ready", pcm_ready, 1'b1);
    check("reset_underrun", underrun, 1'b0);
`ifdef PDM_TX_UNDERRUN_CNT_EN
    check("reset_underrun_cnt", underrun_cnt, 16'd0);
`endif
    rst = 1'b0;

    // Density table: constant input from a fresh start, ones counted over the second OSR window
    for (int v = 0; v < 4; v++) begin
      do_reset();
      for (int k = 0; k < 4; k++) src_q.push_back(vecs[v].x);
      start_run();
      under_seen = 0;
      ones = 0;
      run_strobes(1);
      check("first_bit", last_bit, 1'b1);
      run_strobes(49);
      ones = 0;
      run_strobes(50);
      check_range("density_window", ones, vecs[v].lo, vecs[v].hi);
      check("density_no_underrun", under_seen, 0);
      en = 1'b0;
      repeat (2) cycle(1'b0);
    end

    // Handshake with incrementing samples, en toggled mid-stream while the buffer is full
    do_reset();
    for (int k = 0; k < 6; k++) src_q.push_back(k * 5000 - 12000);
    start_run();
    run_strobes(120);
    en = 1'b0;
    repeat (3) cycle(1'b0);
    cycle(1'b1);
    cycle(1'b0);
    start_run();
    run_strobes(200);
    check("handshake_all_accepted", src_q.size(), 0);

    // Underrun: two samples then silence -> boundaries 100, 150, 200 starve
    do_reset();
    src_q.push_back(12000);
    src_q.push_back(-7000);
    start_run();
    under_seen = 0;
    run_strobes(250);
    check("underrun_pulses", under_seen, 3);
`ifdef PDM_TX_UNDERRUN_CNT_EN
    check("underrun_cnt_3", underrun_cnt, 16'd3);
`endif

    // Reset mid-RUN with a full buffer holding a sample that must never be emitted
    do_reset();
    src_q.push_back(0);
    src_q.push_back(0);
    src_q.push_back(-32768);
    start_run();
    run_strobes(51);
    check("pre_rst_m_data", M_DATA, 1'b1);
    check("pre_rst_full", pcm_ready, 1'b0);
    rst = 1'b1;
    #1;
    check("async_rst_m_data", M_DATA, 1'b0);
    check("async_rst_pcm_ready", pcm_ready, 1'b1);
    check("async_rst_underrun", underrun, 1'b0);
    do_reset();
    start_run();
    under_seen = 0;
    ones = 0;
    run_strobes(100);
    check("post_rst_ones", ones, 50);
    check("post_rst_underruns", under_seen, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_tx.md
Name: pdm_tx

Overview:
- PDM transmitter: the other end of the pdm_mic receiver link.
- Accepts signed PCM samples over a valid/ready handshake and holds each for OSR PDM clocks.
- A first-order sigma-delta modulator turns each sample into a 1-bit PDM stream, timed by the m_clk_rising strobe from clk_gen.
- Used as an on-chip microphone emulator: drives a pdm_mic M_DATA input for closed-loop capture tests of the BRAM path.

Parameters:
- PCM_WIDTH, 16, width of the signed PCM input sample.
- OSR, 50, PDM bits per PCM sample (2.4 MHz / 48 kHz); legal range 2..1023.

Ports:
- clk  in  1  system clock (FCLK_CLK0 domain, 125 MHz).
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  run enable; low forces IDLE.
- m_clk_rising  in  1  single-cycle PDM bit strobe from clk_gen.
- pcm_data  in  PCM_WIDTH  signed two's-complement sample.
- pcm_valid  in  1  pcm_data is valid.
- pcm_ready  out  1  holding buffer can accept a sample.
- M_DATA  out  1  PDM bitstream toward the receiver.
- underrun  out  1  one-cycle pulse when a sample boundary finds the buffer empty.

Behaviour:
- Reset values: M_DATA=0, underrun=0, pcm_ready=1, buffer empty, acc=0, cur=0, osr_cnt=0, state=IDLE.
- Holding buffer: one entry.
  - pcm_ready = !buf_full, driven from a register only; no combinational path from pcm_valid.
  - Accept when pcm_valid && pcm_ready.
  - Data must remain accepted unchanged until consumed.
- States:
  - IDLE: M_DATA=0, acc=0, osr_cnt=0; the buffer may still fill. en=1 -> RUN on the next clk.
  - RUN: en=0 -> IDLE on the next clk; acc and osr_cnt are cleared and buffer contents are kept.
- On each m_clk_rising in RUN:
  - If osr_cnt==0: cur <= buffer and the buffer empties. If the buffer is empty instead, cur <= 0 and underrun pulses for 1 cycle.
  - The modulator uses the newly selected cur value in the same strobe.
  - osr_cnt increments and wraps from OSR-1 to 0.
- Modulator:
  - acc is signed, PCM_WIDTH+2 bits; FS = 2^(PCM_WIDTH-1).
  - bit = (acc >= 0).
  - acc <= acc + sext(cur) - (bit ? FS : -FS).
  - Bounded by construction; no saturation logic.
- Latency: M_DATA is registered and equals bit one clk after the strobe; it holds until the next strobe.
- Density: ones density over an OSR window is (x+FS)/2^PCM_WIDTH, ±1 bit.
  - x=0 gives 1,0,1,0,... starting with 1 after IDLE.
- Simultaneous consume and valid in one cycle: the consume wins. pcm_ready rises the next cycle and no sample is lost or duplicated.
- m_clk_rising while in IDLE is ignored.
- rst mid-stream: immediate return to reset values; any buffered sample is discarded.

Optional Feature:
- Macro: PDM_TX_UNDERRUN_CNT_EN.
- Defined:
  - Adds output port underrun_cnt (16 bits, reset 0).
  - Increments on every underrun pulse and saturates at 0xFFFF.
  - Cleared by rst only.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package pdm_pkg:
  - Default PCM_WIDTH/OSR constants.
  - Two-state enum pdm_tx_state_t (IDLE, RUN).
  - FS/ACC_WIDTH derivation functions.
- Sub-module pdm_sd_mod: a first-order modulator core.
  - Inputs: clk, rst, clr, step strobe, sample.
  - Output: registered bit.
- pdm_tx owns the FSM, buffer, osr_cnt and underrun logic.

Test Plan:
- Reset: assert rst mid-RUN with the buffer full -> M_DATA=0, pcm_ready=1, underrun=0 asynchronously; the buffered sample is not emitted after release.
- Zero input: en=1, feed x=0 continuously -> M_DATA sequence 1,0,1,0... with exactly 25 ones per 50-bit window; underrun never pulses.
- Density: PCM_WIDTH=16, x=16384 for 8 samples -> 37 or 38 ones per 50-bit window. x=-32768 -> 0 ones. x=32767 -> 49 or 50 ones.
- Handshake: hold pcm_valid=1 with an incrementing counter -> one accept per OSR strobes; pcm_ready low while full; no sample dropped or repeated, checked by a reference model comparing the bit stream.
- Underrun: stop pcm_valid after 2 samples -> underrun pulses once at each subsequent boundary (every 50 strobes); output reverts to the alternating zero pattern. With PDM_TX_UNDERRUN_CNT_EN, underrun_cnt=3 after 3 boundaries.
- Loopback: drive pdm_tx into pdm_mic with a 1 kHz sine -> the decoded stream correlates with the input within the pdm_mic filter delay; en toggled low then high restarts with acc=0.
